// File: rtl/pipe_stage_skid.sv
// Two-entry elastic pipeline stage: a main register feeding the outputs plus a
// skid register, so in_ready can be registered without losing throughput.
module pipe_stage_skid #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned SIG_W      = 9,
  parameter bit          FLUSH_DATA = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SIG_W-1:0]  in_sig,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SIG_W-1:0]  out_sig,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state, state_n;
  logic              in_ready_q;
  logic [SIG_W-1:0]  main_sig, skid_sig;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              in_acc, out_acc;
  logic              load_main_in, load_main_skid, load_skid;

  assign in_ready  = in_ready_q;
  assign out_valid = (state != EMPTY);
  assign in_acc    = in_valid && in_ready_q;
  assign out_acc   = out_valid && out_ready;
  assign out_sig   = out_valid ? main_sig : '0;
  assign out_data  = main_data;
  assign occupancy = state;

  always_comb begin
    state_n        = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_acc) begin
          load_main_in = 1'b1;
          state_n      = ONE;
        end
      end
      ONE: begin
        if (in_acc && out_acc) begin
          load_main_in = 1'b1;
        end else if (in_acc) begin
          load_skid = 1'b1;
          state_n   = FULL;
        end else if (out_acc) begin
          state_n = EMPTY;
        end
      end
      FULL: begin
        if (out_acc) begin
          load_main_skid = 1'b1;
          state_n        = ONE;
        end
      end
      default: state_n = EMPTY;
    endcase
    if (flush) begin
      state_n = EMPTY;
    end
  end

  // in_ready is registered from the next state, so it never sees out_ready combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_n;
      in_ready_q <= (state_n != FULL);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_sig  <= '0;
      main_data <= '0;
      skid_sig  <= '0;
      skid_data <= '0;
    end else if (flush) begin
      main_sig <= '0;
      skid_sig <= '0;
      if (FLUSH_DATA) begin
        main_data <= '0;
        skid_data <= '0;
      end
    end else begin
      if (load_main_in) begin
        main_sig  <= in_sig;
        main_data <= in_data;
      end else if (load_main_skid) begin
        main_sig  <= skid_sig;
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_sig  <= in_sig;
        skid_data <= in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && !flush && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: handshake ordering, skid fill/drain,
// flush, stall counter saturation and asynchronous reset.
module tb_pipe_stage_skid;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned SIG_W  = 9;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [SIG_W-1:0]  in_sig = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [SIG_W-1:0]  out_sig;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  pipe_stage_skid #(
    .DATA_W    (DATA_W),
    .SIG_W     (SIG_W),
    .FLUSH_DATA(1'b1),
    .CNT_W     (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sig   (in_sig),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sig  (out_sig),
    .out_data (out_data),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [SIG_W-1:0] s, input logic [DATA_W-1:0] d);
    in_valid = 1'b1;
    in_sig   = s;
    in_data  = d;
  endtask

  initial begin
    // Reset held with the clock running
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sig", out_sig, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_stall", stall_cnt, 0);
    step();
    rst = 1'b0;

    // Single entry, 1-cycle latency
    offer(9'h1FF, 64'hA5);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("one_valid", out_valid, 1);
    chk("one_data", out_data, 64'hA5);
    chk("one_sig", out_sig, 9'h1FF);
    chk("one_occ", occupancy, 1);
    step();
    chk("one_drain_valid", out_valid, 0);
    chk("one_bubble_sig", out_sig, 0);

    // Full-rate stream
    for (int i = 0; i < 10; i++) begin
      offer(9'(i + 1), 64'(i));
      step();
      chk("stream_valid", out_valid, 1);
      chk("stream_data", out_data, 64'(i));
      chk("stream_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_end_valid", out_valid, 0);
    chk("stream_stall", stall_cnt, 0);

    // Back-pressure fills the skid entry
    out_ready = 1'b0;
    offer(9'h011, 64'h11);
    step();
    offer(9'h022, 64'h22);
    step();
    offer(9'h033, 64'h33);
    step();
    chk("bp_occ", occupancy, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_head", out_data, 64'h11);
    step();
    chk("bp_head_hold", out_data, 64'h11);
    chk("bp_stall3", stall_cnt, 3);
    out_ready = 1'b1;
    step();
    chk("bp_second", out_data, 64'h22);
    chk("bp_second_sig", out_sig, 9'h022);
    chk("bp_occ1", occupancy, 1);
    step();
    in_valid = 1'b0;
    chk("bp_third", out_data, 64'h33);
    chk("bp_third_valid", out_valid, 1);
    step();
    chk("bp_empty", out_valid, 0);
    chk("bp_stall_final", stall_cnt, 3);

    // Flush while full, with a competing input
    out_ready = 1'b0;
    offer(9'h0AA, 64'h44);
    step();
    offer(9'h0BB, 64'h55);
    step();
    chk("fl_pre_occ", occupancy, 2);
    flush = 1'b1;
    offer(9'h0CC, 64'h66);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_sig", out_sig, 0);
    chk("fl_occ", occupancy, 0);
    chk("fl_in_ready", in_ready, 1);
    chk("fl_data", out_data, 0);
    out_ready = 1'b1;
    step();
    chk("fl_no_ghost", out_valid, 0);
    chk("fl_stall_kept", stall_cnt, 4);

    // Asynchronous reset between edges while full
    out_ready = 1'b0;
    offer(9'h077, 64'h77);
    step();
    offer(9'h088, 64'h88);
    step();
    in_valid = 1'b0;
    chk("ar_pre_occ", occupancy, 2);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_occ", occupancy, 0);
    chk("ar_in_ready", in_ready, 1);
    chk("ar_data", out_data, 0);
    chk("ar_sig", out_sig, 0);
    chk("ar_stall", stall_cnt, 0);
    rst = 1'b0;
    offer(9'h099, 64'h99);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("ar_first_valid", out_valid, 1);
    chk("ar_first_data", out_data, 64'h99);
    step();

    // Stall counter saturation with CNT_W=4
    out_ready = 1'b0;
    offer(9'h0BB, 64'hBB);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("sat_15", stall_cnt, 15);
    step();
    step();
    chk("sat_hold", stall_cnt, 15);
    chk("sat_entry", out_data, 64'hBB);
    chk("sat_occ", occupancy, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
